// File: rtl/cam_wr_pack.sv
// cam_wr_pack: DVP byte stream -> RGB565 pixels -> 128-bit write-FIFO words,
// plus the frame-start wr_load pulse, frame counter and sticky overflow flag.
// Optional build macro CAM_FRAME_DROP_EN: discard the first FRAME_DROP frames
// after reset; without it the first vsync rise after reset starts capture.
module cam_wr_pack #(
    parameter int FRAME_DROP  = 10,
    parameter int WR_LOAD_LEN = 4
) (
    input  logic         cam_pclk,
    input  logic         rst_n,
    input  logic         cam_vsync,
    input  logic         cam_href,
    input  logic [7:0]   cam_data,
    input  logic         wfifo_full,
    output logic         wfifo_wr_en,
    output logic [127:0] wfifo_din,
    output logic         wr_load,
    output logic         wr_overflow,
    output logic [15:0]  frame_cnt
);

    localparam logic [3:0] LOAD_N = 4'(WR_LOAD_LEN);

`ifdef CAM_FRAME_DROP_EN
    localparam logic [7:0] DROP_N = 8'(FRAME_DROP);
    typedef enum logic {ST_DROP = 1'b0, ST_CAPTURE = 1'b1} state_e;
    localparam state_e ST_RESET = ST_DROP;
    logic [7:0]   drop_cnt_q, drop_cnt_d;
`else
    typedef enum logic {ST_WAIT = 1'b0, ST_CAPTURE = 1'b1} state_e;
    localparam state_e ST_RESET = ST_WAIT;
    logic         unused_frame_drop;
    assign unused_frame_drop = ^FRAME_DROP;
`endif

    logic         vs_d0_q, vs_d1_q, hr_d0_q;
    logic [7:0]   dat_d0_q;
    state_e       state_q, state_d;
    logic         phase_q, phase_d;
    logic [7:0]   hi_q, hi_d;
    logic [2:0]   pix_idx_q, pix_idx_d;
    logic [111:0] word_q, word_d;     // pixels 0..6; pixel 7 goes straight out
    logic         wr_en_q, wr_en_d;
    logic [127:0] din_q, din_d;
    logic [3:0]   load_cnt_q, load_cnt_d;
    logic         ovf_q, ovf_d;
    logic [15:0]  frame_cnt_q, frame_cnt_d;
    logic         vs_rise, frame_start, byte_ok;
    logic [15:0]  pixel;

    assign vs_rise = vs_d0_q & ~vs_d1_q;
    assign byte_ok = (state_q == ST_CAPTURE) & ~vs_d0_q & hr_d0_q;
    assign pixel   = {hi_q, dat_d0_q};

    // Frame-start detection and capture-state sequencing
    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
`ifdef CAM_FRAME_DROP_EN
        drop_cnt_d  = drop_cnt_q;
`endif
        if (vs_rise) begin
            if (state_q == ST_CAPTURE) begin
                frame_start = 1'b1;
            end else begin
`ifdef CAM_FRAME_DROP_EN
                drop_cnt_d = drop_cnt_q + 8'd1;
                if (drop_cnt_q == DROP_N) begin
                    state_d     = ST_CAPTURE;
                    frame_start = 1'b1;
                end
`else
                state_d     = ST_CAPTURE;
                frame_start = 1'b1;
`endif
            end
        end
    end

    // Byte pairing, pixel packing, word output and frame bookkeeping
    always_comb begin
        phase_d     = 1'b0;
        hi_d        = hi_q;
        pix_idx_d   = pix_idx_q;
        word_d      = word_q;
        wr_en_d     = 1'b0;
        din_d       = din_q;
        ovf_d       = ovf_q;
        frame_cnt_d = frame_cnt_q;
        load_cnt_d  = (load_cnt_q != 4'd0) ? load_cnt_q - 4'd1 : 4'd0;
        if (frame_start) begin
            // A stale partial word is discarded simply by restarting at slot 0.
            load_cnt_d  = LOAD_N;
            frame_cnt_d = frame_cnt_q + 16'd1;
            ovf_d       = 1'b0;
            pix_idx_d   = 3'd0;
        end else if (byte_ok) begin
            phase_d = ~phase_q;
            if (!phase_q) begin
                hi_d = dat_d0_q;
            end else begin
                pix_idx_d = pix_idx_q + 3'd1;
                if (pix_idx_q == 3'd7) begin
                    if (wfifo_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        wr_en_d = 1'b1;
                        din_d   = {pixel, word_q};
                    end
                end else begin
                    for (int i = 0; i < 7; i++) begin
                        if (pix_idx_q == 3'(i)) word_d[16*i +: 16] = pixel;
                    end
                end
            end
        end
    end

    // Control state; vsync history resets high so a vsync already high at
    // reset release is not mistaken for a frame start
    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d0_q     <= 1'b1;
            vs_d1_q     <= 1'b1;
            hr_d0_q     <= 1'b0;
            state_q     <= ST_RESET;
            phase_q     <= 1'b0;
            pix_idx_q   <= 3'd0;
            wr_en_q     <= 1'b0;
            din_q       <= '0;
            load_cnt_q  <= 4'd0;
            ovf_q       <= 1'b0;
            frame_cnt_q <= 16'd0;
`ifdef CAM_FRAME_DROP_EN
            drop_cnt_q  <= 8'd0;
`endif
        end else begin
            vs_d0_q     <= cam_vsync;
            vs_d1_q     <= vs_d0_q;
            hr_d0_q     <= cam_href;
            state_q     <= state_d;
            phase_q     <= phase_d;
            pix_idx_q   <= pix_idx_d;
            wr_en_q     <= wr_en_d;
            din_q       <= din_d;
            load_cnt_q  <= load_cnt_d;
            ovf_q       <= ovf_d;
            frame_cnt_q <= frame_cnt_d;
`ifdef CAM_FRAME_DROP_EN
            drop_cnt_q  <= drop_cnt_d;
`endif
        end
    end

    // Data-only registers: input byte, pending high byte, partial word
    always_ff @(posedge cam_pclk) begin
        dat_d0_q <= cam_data;
        hi_q     <= hi_d;
        word_q   <= word_d;
    end

    assign wfifo_wr_en = wr_en_q;
    assign wfifo_din   = din_q;
    assign wr_load     = (load_cnt_q != 4'd0);
    assign wr_overflow = ovf_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_cam_wr_pack.sv
// Testbench for cam_wr_pack: scenario tasks with a pixel-queue reference model.
`timescale 1ns/1ps
module tb_cam_wr_pack;
    localparam int FRAME_DROP  = 2;
    localparam int WR_LOAD_LEN = 4;
    localparam logic [127:0] W_00_0F = 128'h0E0F_0C0D_0A0B_0809_0607_0405_0203_0001;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cam_vsync = 1'b0, cam_href = 1'b0, wfifo_full = 1'b0;
    logic [7:0]   cam_data = 8'd0;
    logic         wfifo_wr_en, wr_load, wr_overflow;
    logic [127:0] wfifo_din;
    logic [15:0]  frame_cnt;

    always #5 clk = ~clk;

    cam_wr_pack #(.FRAME_DROP(FRAME_DROP), .WR_LOAD_LEN(WR_LOAD_LEN)) dut (
        .cam_pclk(clk), .rst_n(rst_n), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_data(cam_data), .wfifo_full(wfifo_full), .wfifo_wr_en(wfifo_wr_en),
        .wfifo_din(wfifo_din), .wr_load(wr_load), .wr_overflow(wr_overflow),
        .frame_cnt(frame_cnt)
    );

    typedef struct { int step; logic [127:0] din; } evt_t;
    evt_t obs_evt[$], exp_evt[$];
    int   obs_load[$], exp_load[$];
    int   tests_run = 0, tests_failed = 0;
    int   step_n = 0, last_drive = 0, last_rise = 0;
    logic full_v = 1'b0;
    logic p_vs = 1'b0, p_vs2 = 1'b0, p_hr = 1'b0;
    logic [7:0] p_dat = 8'd0;

    // Reference model state (pin-level view of frames, bytes and pixels)
    bit          mdl_capt, mdl_ovf, mdl_ovf_vis, mdl_hi_ok;
    int          mdl_rises, mdl_load;
    logic [15:0] mdl_fc, mdl_fc_vis;
    logic [7:0]  mdl_hi;
    logic [15:0] mdl_pix[$];

    task automatic clear_logs();
        obs_evt.delete(); exp_evt.delete(); obs_load.delete(); exp_load.delete();
    endtask

    task automatic model_reset();
        mdl_capt = 0; mdl_rises = 0; mdl_load = 0; mdl_fc = 0; mdl_fc_vis = 0;
        mdl_ovf = 0; mdl_ovf_vis = 0; mdl_hi_ok = 0; mdl_hi = 0; mdl_pix.delete();
        p_vs = 0; p_vs2 = 0; p_hr = 0; p_dat = 0;
        clear_logs();
    endtask

    // Effect of the byte/vsync seen one step ago, visible one step from now.
    task automatic mdl_update(input logic vs1, input logic vs2, input logic hr1,
                              input logic [7:0] d1, input logic full_now);
        logic [127:0] w;
        bit start;
        evt_t e;
        start = 0;
        if (mdl_load > 0) mdl_load--;
        if (vs1 && !vs2) begin
            if (mdl_capt) start = 1;
            else begin
                mdl_rises++;
`ifdef CAM_FRAME_DROP_EN
                if (mdl_rises > FRAME_DROP) begin mdl_capt = 1; start = 1; end
`else
                mdl_capt = 1; start = 1;
`endif
            end
            if (start) begin
                mdl_load = WR_LOAD_LEN; mdl_fc = mdl_fc + 16'd1; mdl_ovf = 0;
                mdl_pix.delete(); mdl_hi_ok = 0;
            end
        end else if (mdl_capt && hr1 && !vs1) begin
            if (!mdl_hi_ok) begin
                mdl_hi = d1; mdl_hi_ok = 1;
            end else begin
                mdl_pix.push_back({mdl_hi, d1}); mdl_hi_ok = 0;
                if (mdl_pix.size() == 8) begin
                    w = '0;
                    for (int i = 0; i < 8; i++) w[16*i +: 16] = mdl_pix[i];
                    if (full_now) mdl_ovf = 1;
                    else begin e.step = step_n + 1; e.din = w; exp_evt.push_back(e); end
                    mdl_pix.delete();
                end
            end
        end else begin
            mdl_hi_ok = 0;
        end
        if (mdl_load > 0) exp_load.push_back(step_n + 1);
    endtask

    // One clock: record outputs at the falling edge, then drive new inputs.
    task automatic step(input logic vs, input logic hr, input logic [7:0] d);
        evt_t e;
        @(negedge clk);
        if (wfifo_wr_en === 1'b1) begin e.step = step_n; e.din = wfifo_din; obs_evt.push_back(e); end
        if (wr_load === 1'b1) obs_load.push_back(step_n);
        mdl_ovf_vis = mdl_ovf; mdl_fc_vis = mdl_fc;
        cam_vsync = vs; cam_href = hr; cam_data = d; wfifo_full = full_v;
        if (vs && !p_vs) last_rise = step_n;
        mdl_update(p_vs, p_vs2, p_hr, p_dat, full_v);
        p_vs2 = p_vs; p_vs = vs; p_hr = hr; p_dat = d;
        last_drive = step_n;
        step_n++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_seq(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, base + 8'(i));
    endtask

    task automatic send_rand(input int n);
        for (int i = 0; i < n; i++) begin
            full_v = ($urandom_range(0, 3) == 0);
            step(1'b0, 1'b1, 8'($urandom));
        end
        full_v = 1'b0;
    endtask

    task automatic vsync_pulse();
        repeat (3) step(1'b1, 1'b0, 8'h00);
        idle(3);
    endtask

    task automatic enter_capture();
`ifdef CAM_FRAME_DROP_EN
        repeat (FRAME_DROP + 1) vsync_pulse();
`else
        vsync_pulse();
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; cam_vsync = 0; cam_href = 0; cam_data = 0; wfifo_full = 0; full_v = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        idle(2);
        tests_run++;
        if (wfifo_wr_en !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_en: got %b expected 0", wfifo_wr_en); end
        tests_run++;
        if (wfifo_din !== 128'd0) begin tests_failed++; $display("FAIL reset_din: got %h expected 0", wfifo_din); end
        tests_run++;
        if (wr_load !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_load: got %b expected 0", wr_load); end
        tests_run++;
        if (wr_overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b expected 0", wr_overflow); end
        tests_run++;
        if (frame_cnt !== 16'd0) begin tests_failed++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
        send_seq(32, 8'h00);
        idle(3);
        tests_run++;
        if (obs_evt.size() != 0 || obs_load.size() != 0) begin
            tests_failed++;
            $display("FAIL precapture_ignored: got %0d words %0d load cycles expected 0 0", obs_evt.size(), obs_load.size());
        end
    endtask

    task automatic test_single_word();
        int lb, first_ld, last_ld;
        do_reset();
        enter_capture();
        first_ld = (obs_load.size() > 0) ? obs_load[0] : -1;
        last_ld  = (obs_load.size() > 0) ? obs_load[obs_load.size()-1] : -1;
        tests_run++;
        if (obs_load.size() != WR_LOAD_LEN || first_ld != last_rise + 2 || last_ld != last_rise + WR_LOAD_LEN + 1) begin
            tests_failed++;
            $display("FAIL wr_load_pulse: got len %0d first %0d last %0d expected len %0d first %0d",
                     obs_load.size(), first_ld, last_ld, WR_LOAD_LEN, last_rise + 2);
        end
        send_seq(16, 8'h00);
        lb = last_drive;
        idle(5);
        tests_run++;
        if (obs_evt.size() != 1) begin
            tests_failed++; $display("FAIL single_word_count: got %0d expected 1", obs_evt.size());
        end else begin
            tests_run++;
            if (obs_evt[0].din !== W_00_0F) begin tests_failed++; $display("FAIL single_word_din: got %h expected %h", obs_evt[0].din, W_00_0F); end
            tests_run++;
            if (obs_evt[0].step != lb + 2) begin tests_failed++; $display("FAIL single_word_latency: got step %0d expected %0d", obs_evt[0].step, lb + 2); end
        end
        tests_run++;
        if (wfifo_din !== W_00_0F) begin tests_failed++; $display("FAIL din_hold: got %h expected %h", wfifo_din, W_00_0F); end
        tests_run++;
        if (obs_load != exp_load) begin tests_failed++; $display("FAIL wr_load_model: got %0d cycles expected %0d", obs_load.size(), exp_load.size()); end
    endtask

    task automatic test_frame_drop();
        int exp_words, exp_frames;
`ifdef CAM_FRAME_DROP_EN
        exp_words = 8; exp_frames = 2;
`else
        exp_words = 16; exp_frames = 4;
`endif
        do_reset();
        repeat (4) begin
            vsync_pulse();
            repeat (2) begin send_seq(32, 8'($urandom)); idle(2); end
        end
        idle(4);
        tests_run++;
        if (obs_evt.size() != exp_words) begin tests_failed++; $display("FAIL drop_words: got %0d expected %0d", obs_evt.size(), exp_words); end
        tests_run++;
        if (obs_load.size() != exp_frames * WR_LOAD_LEN) begin
            tests_failed++; $display("FAIL drop_load_cycles: got %0d expected %0d", obs_load.size(), exp_frames * WR_LOAD_LEN);
        end
        tests_run++;
        if (frame_cnt !== 16'(exp_frames)) begin tests_failed++; $display("FAIL drop_frame_cnt: got %0d expected %0d", frame_cnt, exp_frames); end
        tests_run++;
        if (obs_evt.size() != exp_evt.size()) begin
            tests_failed++; $display("FAIL drop_model_count: got %0d expected %0d", obs_evt.size(), exp_evt.size());
        end else foreach (obs_evt[i]) begin
            tests_run++;
            if (obs_evt[i].step != exp_evt[i].step || obs_evt[i].din !== exp_evt[i].din) begin
                tests_failed++; $display("FAIL drop_word%0d: got %0d/%h expected %0d/%h", i, obs_evt[i].step, obs_evt[i].din, exp_evt[i].step, exp_evt[i].din);
            end
        end
    endtask

    task automatic test_odd_byte();
        logic [127:0] w2;
        w2 = 128'h3031_2C2D_2A2B_2829_2627_2425_2223_2021;
        do_reset();
        enter_capture();
        clear_logs();
        send_seq(17, 8'h00);
        idle(2);
        send_seq(15, 8'h20);
        idle(3);
        tests_run++;
        if (obs_evt.size() != 1 || obs_evt[obs_evt.size() > 0 ? 0 : 0].din !== W_00_0F) begin
            tests_failed++; $display("FAIL odd_first_word: got %0d words expected 1 of %h", obs_evt.size(), W_00_0F);
        end
        send_seq(2, 8'h30);
        idle(3);
        tests_run++;
        if (obs_evt.size() != 2) begin
            tests_failed++; $display("FAIL odd_word_count: got %0d expected 2", obs_evt.size());
        end else begin
            tests_run++;
            if (obs_evt[1].din !== w2) begin tests_failed++; $display("FAIL odd_second_word: got %h expected %h", obs_evt[1].din, w2); end
        end
        tests_run++;
        if (obs_evt.size() != exp_evt.size()) begin
            tests_failed++; $display("FAIL odd_model_count: got %0d expected %0d", obs_evt.size(), exp_evt.size());
        end else foreach (obs_evt[i]) begin
            tests_run++;
            if (obs_evt[i].step != exp_evt[i].step || obs_evt[i].din !== exp_evt[i].din) begin
                tests_failed++; $display("FAIL odd_word%0d: got %0d/%h expected %0d/%h", i, obs_evt[i].step, obs_evt[i].din, exp_evt[i].step, exp_evt[i].din);
            end
        end
    endtask

    task automatic test_overflow();
        logic [15:0] fc_before;
        do_reset();
        enter_capture();
        clear_logs();
        send_seq(16, 8'h10);
        idle(2);
        full_v = 1'b1;
        send_seq(16, 8'h50);
        idle(1);
        full_v = 1'b0;
        idle(2);
        send_seq(16, 8'h90);
        idle(3);
        tests_run++;
        if (obs_evt.size() != 2) begin
            tests_failed++; $display("FAIL ovf_strobes: got %0d expected 2", obs_evt.size());
        end else begin
            tests_run++;
            if (obs_evt[0].din[15:0] !== 16'h1011 || obs_evt[1].din[15:0] !== 16'h9091) begin
                tests_failed++; $display("FAIL ovf_kept_words: got %h %h expected 1011 9091", obs_evt[0].din[15:0], obs_evt[1].din[15:0]);
            end
        end
        tests_run++;
        if (wr_overflow !== 1'b1 || mdl_ovf_vis != 1'b1) begin
            tests_failed++; $display("FAIL ovf_set: got %b expected 1", wr_overflow);
        end
        fc_before = frame_cnt;
        vsync_pulse();
        tests_run++;
        if (wr_overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_clear: got %b expected 0", wr_overflow); end
        tests_run++;
        if (frame_cnt !== fc_before + 16'd1 || frame_cnt !== mdl_fc_vis) begin
            tests_failed++; $display("FAIL ovf_frame_cnt: got %0d expected %0d", frame_cnt, mdl_fc_vis);
        end
    endtask

    task automatic test_partial_vsync();
        logic [127:0] w;
        w = 128'h4E4F_4C4D_4A4B_4849_4647_4445_4243_4041;
        do_reset();
        enter_capture();
        clear_logs();
        send_seq(10, 8'hA0);
        idle(2);
        vsync_pulse();
        send_seq(16, 8'h40);
        idle(3);
        tests_run++;
        if (obs_evt.size() != 1) begin
            tests_failed++; $display("FAIL partial_count: got %0d expected 1", obs_evt.size());
        end else begin
            tests_run++;
            if (obs_evt[0].din !== w || obs_evt[0].step != exp_evt[0].step) begin
                tests_failed++; $display("FAIL partial_word: got %h expected %h", obs_evt[0].din, w);
            end
        end
    endtask

    task automatic test_reset_mid_word();
        do_reset();
        enter_capture();
        send_seq(22, 8'h60);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (wfifo_wr_en !== 1'b0 || wfifo_din !== 128'd0 || wr_load !== 1'b0 ||
            wr_overflow !== 1'b0 || frame_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL async_reset: got en %b din %h load %b ovf %b fc %0d expected all 0",
                     wfifo_wr_en, wfifo_din, wr_load, wr_overflow, frame_cnt);
        end
        @(negedge clk);
        cam_href = 1'b0;
        rst_n = 1'b1;
        model_reset();
        send_seq(16, 8'h80);
        idle(3);
        tests_run++;
        if (obs_evt.size() != 0 || obs_load.size() != 0) begin
            tests_failed++; $display("FAIL post_reset_idle: got %0d words %0d load cycles expected 0 0", obs_evt.size(), obs_load.size());
        end
        enter_capture();
        send_seq(16, 8'h90);
        idle(3);
        tests_run++;
        if (obs_evt.size() != 1 || exp_evt.size() != 1) begin
            tests_failed++; $display("FAIL post_reset_word_count: got %0d expected 1", obs_evt.size());
        end else begin
            tests_run++;
            if (obs_evt[0].din !== exp_evt[0].din || obs_evt[0].din[15:0] !== 16'h9091) begin
                tests_failed++; $display("FAIL post_reset_word: got %h expected %h", obs_evt[0].din, exp_evt[0].din);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        enter_capture();
        clear_logs();
        repeat (3) begin
            repeat (5) begin
                send_rand(int'($urandom_range(1, 40)));
                idle(int'($urandom_range(1, 3)));
            end
            vsync_pulse();
        end
        repeat (4) begin send_rand(int'($urandom_range(8, 40))); idle(2); end
        idle(3);
        tests_run++;
        if (obs_evt.size() != exp_evt.size()) begin
            tests_failed++; $display("FAIL rand_count: got %0d expected %0d", obs_evt.size(), exp_evt.size());
        end else foreach (obs_evt[i]) begin
            tests_run++;
            if (obs_evt[i].step != exp_evt[i].step || obs_evt[i].din !== exp_evt[i].din) begin
                tests_failed++; $display("FAIL rand_word%0d: got %0d/%h expected %0d/%h", i, obs_evt[i].step, obs_evt[i].din, exp_evt[i].step, exp_evt[i].din);
            end
        end
        tests_run++;
        if (wr_overflow !== mdl_ovf_vis) begin tests_failed++; $display("FAIL rand_overflow: got %b expected %b", wr_overflow, mdl_ovf_vis); end
        tests_run++;
        if (frame_cnt !== mdl_fc_vis) begin tests_failed++; $display("FAIL rand_frame_cnt: got %0d expected %0d", frame_cnt, mdl_fc_vis); end
        tests_run++;
        if (obs_load != exp_load) begin tests_failed++; $display("FAIL rand_wr_load: got %0d cycles expected %0d", obs_load.size(), exp_load.size()); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_word();
        test_frame_drop();
        test_odd_byte();
        test_overflow();
        test_partial_vsync();
        test_reset_mid_word();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
